// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU control decoder: op encodings,
// ALU/MDU control codes, func7 classes and latency helpers.
package alu_pkg;

  localparam int CODE_W = 5;
  typedef logic [CODE_W-1:0] code_t;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE = 2'b10;
  localparam logic [1:0] ALU_OP_ITYPE = 2'b11;

  localparam code_t CTRL_AND    = 5'd0;
  localparam code_t CTRL_OR     = 5'd1;
  localparam code_t CTRL_ADD    = 5'd2;
  localparam code_t CTRL_SLL    = 5'd3;
  localparam code_t CTRL_SRL    = 5'd4;
  localparam code_t CTRL_XOR    = 5'd5;
  localparam code_t CTRL_SUB    = 5'd6;
  localparam code_t CTRL_SLT    = 5'd7;
  localparam code_t CTRL_MUL    = 5'd8;
  localparam code_t CTRL_MULH   = 5'd9;
  localparam code_t CTRL_MULHSU = 5'd10;
  localparam code_t CTRL_MULHU  = 5'd11;
  localparam code_t CTRL_DIV    = 5'd12;
  localparam code_t CTRL_DIVU   = 5'd13;
  localparam code_t CTRL_REM    = 5'd14;
  localparam code_t CTRL_REMU   = 5'd15;
  localparam code_t CTRL_SRA    = 5'd16;
  localparam code_t CTRL_SLTU   = 5'd17;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic {ST_IDLE, ST_BUSY} mc_state_e;

  // The M-extension block occupies the contiguous range MUL..REMU.
  function automatic logic is_multicycle(code_t code);
    return (code >= CTRL_MUL) && (code <= CTRL_REMU);
  endfunction

  function automatic int lat_select(logic is_mul, logic is_div, int mul_lat, int div_lat);
    if (is_div) return div_lat;
    if (is_mul) return mul_lat;
    return 1;
  endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational RV32I+M decoder: maps alu_op/func7/func3 to an ALU/MDU code,
// flags unsupported encodings and classifies multiplier/divider ops.
module alu_decode
  import alu_pkg::*;
#(
  parameter bit EN_DIV = 1'b1
) (
  input  logic [1:0] alu_op,
  input  logic [6:0] func7,
  input  logic [2:0] func3,
  output code_t      code,
  output logic       illegal,
  output logic       is_mul,
  output logic       is_div
);

  function automatic code_t base_op(logic [2:0] f3);
    case (f3)
      3'b000:  return CTRL_ADD;
      3'b001:  return CTRL_SLL;
      3'b010:  return CTRL_SLT;
      3'b011:  return CTRL_SLTU;
      3'b100:  return CTRL_XOR;
      3'b101:  return CTRL_SRL;
      3'b110:  return CTRL_OR;
      default: return CTRL_AND;
    endcase
  endfunction

  function automatic code_t m_op(logic [2:0] f3);
    case (f3)
      3'b000:  return CTRL_MUL;
      3'b001:  return CTRL_MULH;
      3'b010:  return CTRL_MULHSU;
      3'b011:  return CTRL_MULHU;
      3'b100:  return CTRL_DIV;
      3'b101:  return CTRL_DIVU;
      3'b110:  return CTRL_REM;
      default: return CTRL_REMU;
    endcase
  endfunction

  // Illegal encodings leave code at 0 so no multi-cycle op can be started.
  always_comb begin
    code    = CTRL_AND;
    illegal = 1'b0;
    is_mul  = 1'b0;
    is_div  = 1'b0;
    case (alu_op)
      ALU_OP_ADD: code = CTRL_ADD;
      ALU_OP_SUB: code = CTRL_SUB;
      ALU_OP_RTYPE: begin
        if (func7 == F7_BASE) begin
          code = base_op(func3);
        end else if (func7 == F7_ALT) begin
          if (func3 == 3'b000)      code = CTRL_SUB;
          else if (func3 == 3'b101) code = CTRL_SRA;
          else                      illegal = 1'b1;
        end else if (func7 == F7_MULDIV) begin
          if (func3[2] && !EN_DIV) begin
            illegal = 1'b1;
          end else begin
            code   = m_op(func3);
            is_mul = !func3[2];
            is_div = func3[2];
          end
        end else begin
          illegal = 1'b1;
        end
      end
      default: begin
        // I-type: func7 only qualifies the shift-immediate forms.
        if (func3 == 3'b001) begin
          if (func7 == F7_BASE) code = CTRL_SLL;
          else                  illegal = 1'b1;
        end else if (func3 == 3'b101) begin
          if (func7 == F7_BASE)     code = CTRL_SRL;
          else if (func7 == F7_ALT) code = CTRL_SRA;
          else                      illegal = 1'b1;
        end else begin
          code = base_op(func3);
        end
      end
    endcase
  end

endmodule

// File: rtl/alu_control_mc.sv
// EX-stage ALU control: combinational decode plus an IDLE/BUSY sequencer that
// stalls the pipeline for multiply/divide latency and pulses start/done.
module alu_control_mc
  import alu_pkg::*;
#(
  parameter int CTRL_W  = 5,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter bit EN_DIV  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        alu_op,
  input  logic [6:0]        func7,
  input  logic [2:0]        func3,
  input  logic              ex_valid,
  input  logic              flush,
  output logic [CTRL_W-1:0] alu_control,
  output logic              mc_start,
  output logic              mc_done,
  output logic              stall,
  output logic              illegal
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;

  mc_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  code_t            op_q, op_nxt;

  code_t            dec_code;
  logic             dec_illegal;
  logic             dec_is_mul;
  logic             dec_is_div;
  logic             abort;
  logic             accept;
  logic [CNT_W-1:0] lat_m1;

  alu_decode #(
    .EN_DIV (EN_DIV)
  ) u_decode (
    .alu_op  (alu_op),
    .func7   (func7),
    .func3   (func3),
    .code    (dec_code),
    .illegal (dec_illegal),
    .is_mul  (dec_is_mul),
    .is_div  (dec_is_div)
  );

  assign abort  = rst || flush;
  assign accept = (state == ST_IDLE) && ex_valid && !abort && is_multicycle(dec_code);
  assign lat_m1 = CNT_W'(lat_select(dec_is_mul, dec_is_div, MUL_LAT, DIV_LAT) - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      op_q  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      op_q  <= op_nxt;
    end
  end

  // Flush kills the in-flight op outright; the done pulse is never issued.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    op_nxt    = op_q;
    if (flush) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
      op_nxt    = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state_nxt = ST_BUSY;
            cnt_nxt   = lat_m1;
            op_nxt    = dec_code;
          end
        end
        default: begin
          if (cnt != '0) cnt_nxt = cnt - CNT_W'(1);
          else           state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    alu_control = CTRL_W'(dec_code);
    illegal     = dec_illegal;
    mc_start    = 1'b0;
    mc_done     = 1'b0;
    stall       = 1'b0;
    if (!abort) begin
      case (state)
        ST_IDLE: begin
          mc_start = accept;
          stall    = accept;
        end
        default: begin
          alu_control = CTRL_W'(op_q);
          illegal     = 1'b0;
          if (cnt != '0) stall   = 1'b1;
          else           mc_done = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_control_mc.sv
// Bench for alu_control_mc: two instances (long-latency with divide enabled,
// single-cycle multiply with divide disabled) driven in lockstep.
module tb_alu_control_mc;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_R   = 2'b10;
  localparam logic [1:0] OP_I   = 2'b11;
  localparam logic [6:0] F7_B   = 7'b0000000;
  localparam logic [6:0] F7_ALT = 7'b0100000;
  localparam logic [6:0] F7_M   = 7'b0000001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, flush, ex_valid;
  logic [1:0] alu_op;
  logic [6:0] func7;
  logic [2:0] func3;

  logic [4:0] ctrl_a;
  logic       start_a, done_a, stall_a, ill_a;
  logic [5:0] ctrl_b;
  logic       start_b, done_b, stall_b, ill_b;

  logic [5:0] ctrl_o [2];
  logic [2:0] flags_o[2];
  logic       ill_o  [2];

  int tests_run    = 0;
  int tests_failed = 0;

  int base_tbl[8] = '{2, 3, 7, 17, 5, 4, 1, 0};
  int mul_lat[2]  = '{4, 1};
  int div_lat[2]  = '{32, 3};
  bit en_div[2]   = '{1'b1, 1'b0};

  alu_control_mc #(.CTRL_W(5), .MUL_LAT(4), .DIV_LAT(32), .EN_DIV(1'b1)) dut_a (
    .clk(clk), .rst(rst), .alu_op(alu_op), .func7(func7), .func3(func3),
    .ex_valid(ex_valid), .flush(flush), .alu_control(ctrl_a),
    .mc_start(start_a), .mc_done(done_a), .stall(stall_a), .illegal(ill_a)
  );

  alu_control_mc #(.CTRL_W(6), .MUL_LAT(1), .DIV_LAT(3), .EN_DIV(1'b0)) dut_b (
    .clk(clk), .rst(rst), .alu_op(alu_op), .func7(func7), .func3(func3),
    .ex_valid(ex_valid), .flush(flush), .alu_control(ctrl_b),
    .mc_start(start_b), .mc_done(done_b), .stall(stall_b), .illegal(ill_b)
  );

  assign ctrl_o[0]  = {1'b0, ctrl_a};
  assign ctrl_o[1]  = ctrl_b;
  assign flags_o[0] = {start_a, stall_a, done_a};
  assign flags_o[1] = {start_b, stall_b, done_b};
  assign ill_o[0]   = ill_a;
  assign ill_o[1]   = ill_b;

  // Reference decode straight from the instruction-set tables.
  function automatic void ref_decode(input logic [1:0] op, input logic [6:0] f7,
                                     input logic [2:0] f3, input bit ediv,
                                     output int code, output bit ill);
    code = 0;
    ill  = 1'b0;
    if (op == OP_ADD) code = 2;
    else if (op == 2'b01) code = 6;
    else if (op == OP_R) begin
      if (f7 == F7_B) code = base_tbl[f3];
      else if (f7 == F7_ALT && f3 == 3'd0) code = 6;
      else if (f7 == F7_ALT && f3 == 3'd5) code = 16;
      else if (f7 == F7_M && (f3 < 3'd4 || ediv)) code = 8 + int'(f3);
      else ill = 1'b1;
    end else begin
      if (f3 == 3'd1) begin
        if (f7 == F7_B) code = 3; else ill = 1'b1;
      end else if (f3 == 3'd5) begin
        if (f7 == F7_B) code = 4;
        else if (f7 == F7_ALT) code = 16;
        else ill = 1'b1;
      end else code = base_tbl[f3];
    end
  endfunction

  task automatic applyStimulus(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                               input logic v, input logic fl, input logic r);
    alu_op   = op;
    func7    = f7;
    func3    = f3;
    ex_valid = v;
    flush    = fl;
    rst      = r;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    applyStimulus(OP_ADD, F7_B, 3'd0, 1'b0, 1'b0, 1'b1);
    next_cycle();
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      applyStimulus(OP_R, F7_M, 3'd0, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      tests_run++;
      if ({flags_o[0], flags_o[1]} !== 6'b0) begin
        tests_failed++;
        $display("[TB] FAIL reset_flags: got %b expected %b", {flags_o[0], flags_o[1]}, 6'b0);
      end
      tests_run++;
      if (ctrl_a !== 5'd8 || ctrl_b !== 6'd8) begin
        tests_failed++;
        $display("[TB] FAIL reset_decode: got %0d/%0d expected 8/8", ctrl_a, ctrl_b);
      end
      next_cycle();
    end
    for (int k = 0; k < 3; k++) begin
      applyStimulus(OP_ADD, F7_B, 3'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      tests_run++;
      if ({flags_o[0], flags_o[1], ctrl_a} !== {6'b0, 5'd2}) begin
        tests_failed++;
        $display("[TB] FAIL after_reset: got %b expected %b", {flags_o[0], flags_o[1], ctrl_a}, {6'b0, 5'd2});
      end
      next_cycle();
    end
  endtask

  task automatic test_decode_sweep();
    int  rc;
    bit  ri;
    for (int op = 0; op < 4; op++)
      for (int f7 = 0; f7 < 128; f7++)
        for (int f3 = 0; f3 < 8; f3++) begin
          applyStimulus(2'(op), 7'(f7), 3'(f3), 1'b0, 1'b0, 1'b0);
          @(negedge clk);
          ref_decode(2'(op), 7'(f7), 3'(f3), 1'b1, rc, ri);
          tests_run++;
          if (ctrl_a !== 5'(rc) || ill_a !== ri) begin
            tests_failed++;
            $display("[TB] FAIL decode_a op=%0d f7=%0d f3=%0d: got %0d/%0b expected %0d/%0b",
                     op, f7, f3, ctrl_a, ill_a, rc, ri);
          end
          ref_decode(2'(op), 7'(f7), 3'(f3), 1'b0, rc, ri);
          tests_run++;
          if (ctrl_b !== 6'(rc) || ill_b !== ri) begin
            tests_failed++;
            $display("[TB] FAIL decode_b op=%0d f7=%0d f3=%0d: got %0d/%0b expected %0d/%0b",
                     op, f7, f3, ctrl_b, ill_b, rc, ri);
          end
          next_cycle();
        end
    applyStimulus(OP_R, F7_ALT, 3'd5, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    tests_run++;
    if (ctrl_a !== 5'd16) begin
      tests_failed++;
      $display("[TB] FAIL r_sra: got %0d expected 16", ctrl_a);
    end
    applyStimulus(OP_I, F7_ALT, 3'd0, 1'b0, 1'b0, 1'b0);
    #1;
    tests_run++;
    if (ctrl_a !== 5'd2 || ill_a !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL addi_alt: got %0d/%0b expected 2/0", ctrl_a, ill_a);
    end
    applyStimulus(OP_R, 7'b1000000, 3'd0, 1'b0, 1'b0, 1'b0);
    #1;
    tests_run++;
    if (ctrl_a !== 5'd0 || ill_a !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL r_bad_f7: got %0d/%0b expected 0/1", ctrl_a, ill_a);
    end
    next_cycle();
  endtask

  task automatic test_mul_timing();
    logic [2:0] exp_f;
    do_reset();
    for (int k = 0; k <= 5; k++) begin
      applyStimulus(OP_R, F7_M, 3'd0, k <= 4, 1'b0, 1'b0);
      @(negedge clk);
      exp_f = {k == 0, k < 4, k == 4};
      tests_run++;
      if (flags_o[0] !== exp_f || ctrl_a !== 5'd8) begin
        tests_failed++;
        $display("[TB] FAIL mul_timing k=%0d: start/stall/done,ctrl got %b,%0d expected %b,8",
                 k, flags_o[0], ctrl_a, exp_f);
      end
      next_cycle();
    end
  endtask

  task automatic test_div();
    logic [2:0] exp_f;
    do_reset();
    for (int k = 0; k <= 33; k++) begin
      applyStimulus(OP_R, F7_M, 3'd4, k <= 32, 1'b0, 1'b0);
      @(negedge clk);
      exp_f = {k == 0, k < 32, k == 32};
      tests_run++;
      if (flags_o[0] !== exp_f) begin
        tests_failed++;
        $display("[TB] FAIL div_flags k=%0d: got %b expected %b", k, flags_o[0], exp_f);
      end
      if (k <= 32) begin
        tests_run++;
        if (ctrl_a !== 5'd12) begin
          tests_failed++;
          $display("[TB] FAIL div_ctrl k=%0d: got %0d expected 12", k, ctrl_a);
        end
      end
      tests_run++;
      if ({flags_o[1], ill_b, ctrl_b} !== {3'b000, 1'b1, 6'd0}) begin
        tests_failed++;
        $display("[TB] FAIL div_disabled k=%0d: got %b expected %b", k,
                 {flags_o[1], ill_b, ctrl_b}, {3'b000, 1'b1, 6'd0});
      end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_f;
    do_reset();
    for (int k = 0; k <= 10; k++) begin
      if (k >= 1 && k <= 3)
        applyStimulus(OP_R, 7'($urandom), 3'($urandom), 1'b1, 1'b0, 1'b0);
      else
        applyStimulus(OP_R, F7_M, 3'd0, k <= 9, 1'b0, 1'b0);
      @(negedge clk);
      exp_f = {k == 0 || k == 5, k <= 3 || (k >= 5 && k <= 8), k == 4 || k == 9};
      tests_run++;
      if (flags_o[0] !== exp_f) begin
        tests_failed++;
        $display("[TB] FAIL b2b_flags k=%0d: got %b expected %b", k, flags_o[0], exp_f);
      end
      tests_run++;
      if (ctrl_a !== 5'd8) begin
        tests_failed++;
        $display("[TB] FAIL b2b_ctrl k=%0d: got %0d expected 8", k, ctrl_a);
      end
      next_cycle();
    end
  endtask

  task automatic test_flush();
    logic [2:0] exp_f;
    do_reset();
    for (int k = 0; k <= 8; k++) begin
      if (k <= 2) applyStimulus(OP_R, F7_M, 3'd4, 1'b1, k == 2, 1'b0);
      else        applyStimulus(OP_R, F7_M, 3'd0, k <= 7, 1'b0, 1'b0);
      @(negedge clk);
      exp_f = {k == 0 || k == 3, k < 2 || (k >= 3 && k <= 6), k == 7};
      tests_run++;
      if (flags_o[0] !== exp_f) begin
        tests_failed++;
        $display("[TB] FAIL flush_flags k=%0d: got %b expected %b", k, flags_o[0], exp_f);
      end
      if (k >= 3 && k <= 7) begin
        tests_run++;
        if (ctrl_a !== 5'd8) begin
          tests_failed++;
          $display("[TB] FAIL flush_ctrl k=%0d: got %0d expected 8", k, ctrl_a);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_rst_busy();
    do_reset();
    for (int k = 0; k <= 8; k++) begin
      if (k <= 1)      applyStimulus(OP_R, F7_M, 3'd0, 1'b1, 1'b0, 1'b0);
      else if (k == 2) applyStimulus(OP_R, F7_B, 3'd4, 1'b1, 1'b0, 1'b1);
      else             applyStimulus(OP_ADD, F7_B, 3'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      if (k >= 2) begin
        tests_run++;
        if (flags_o[0] !== 3'b000 || ctrl_a !== ((k == 2) ? 5'd5 : 5'd2)) begin
          tests_failed++;
          $display("[TB] FAIL rst_busy k=%0d: flags,ctrl got %b,%0d expected 000,%0d",
                   k, flags_o[0], ctrl_a, (k == 2) ? 5 : 2);
        end
      end
      next_cycle();
    end
    do_reset();
    for (int k = 0; k <= 5; k++) begin
      applyStimulus(OP_R, F7_M, 3'd0, k <= 1 || k == 3, 1'b0, k == 4);
      @(negedge clk);
      tests_run++;
      if (flags_o[1] !== {k == 0 || k == 3, k == 0 || k == 3, k == 1}) begin
        tests_failed++;
        $display("[TB] FAIL lat1 k=%0d: got %b expected %b", k, flags_o[1],
                 {k == 0 || k == 3, k == 0 || k == 3, k == 1});
      end
      next_cycle();
    end
  endtask

  task automatic test_random();
    bit m_active[2] = '{1'b0, 1'b0};
    int m_t0[2], m_lat[2], m_code[2];
    int rc, e_ctrl, kk;
    bit ri, multi, busy;
    logic [2:0] e_f;
    logic [1:0] op;
    logic [6:0] f7;
    do_reset();
    for (int cyc = 0; cyc < 1200; cyc++) begin
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       f7 = F7_B;
        1:       f7 = F7_ALT;
        2:       f7 = F7_M;
        default: f7 = 7'($urandom);
      endcase
      applyStimulus(op, f7, 3'($urandom), $urandom_range(0, 3) != 0,
                    $urandom_range(0, 19) == 0, $urandom_range(0, 39) == 0);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        ref_decode(alu_op, func7, func3, en_div[d], rc, ri);
        multi  = !ri && rc >= 8 && rc <= 15;
        busy   = 1'b0;
        e_ctrl = rc;
        e_f    = 3'b000;
        if (rst || flush) begin
          m_active[d] = 1'b0;
        end else if (m_active[d]) begin
          busy   = 1'b1;
          kk     = cyc - m_t0[d];
          e_ctrl = m_code[d];
          e_f    = {1'b0, kk < m_lat[d], kk == m_lat[d]};
          if (kk == m_lat[d]) m_active[d] = 1'b0;
        end else if (ex_valid && multi) begin
          e_f         = 3'b110;
          m_active[d] = 1'b1;
          m_t0[d]     = cyc;
          m_code[d]   = rc;
          m_lat[d]    = (rc >= 12) ? div_lat[d] : mul_lat[d];
        end
        tests_run++;
        if (flags_o[d] !== e_f || ctrl_o[d] !== 6'(e_ctrl)) begin
          tests_failed++;
          $display("[TB] FAIL random dut%0d cyc=%0d: flags,ctrl got %b,%0d expected %b,%0d",
                   d, cyc, flags_o[d], ctrl_o[d], e_f, e_ctrl);
        end
        if (!busy) begin
          tests_run++;
          if (ill_o[d] !== ri) begin
            tests_failed++;
            $display("[TB] FAIL random_illegal dut%0d cyc=%0d: got %b expected %b",
                     d, cyc, ill_o[d], ri);
          end
        end
      end
      next_cycle();
    end
  endtask

  initial begin
    applyStimulus(OP_ADD, F7_B, 3'd0, 1'b0, 1'b0, 1'b1);
    test_reset();
    test_decode_sweep();
    test_mul_timing();
    test_div();
    test_back_to_back();
    test_flush();
    test_rst_busy();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alu_control_mc.md
# alu_control_mc

Parametrised successor of the EX-stage ALU control decoder. It decodes `alu_op`/`func7`/`func3` for the full RV32I + M R-type and I-type sets into a wide ALU control code. It also sequences multi-cycle operations (MUL*, DIV*/REM*), with a latency counter, a stall output to the hazard unit, and start/done pulses to the multi-cycle datapath. It sits between the ID/EX pipeline register and the ALU/MDU, replacing the purely combinational decoder.

## Interface
- `CTRL_W`, 5: width of `alu_control`; must be ≥ 5.
- `MUL_LAT`, 4: stall cycles for MUL/MULH/MULHSU/MULHU; must be ≥ 1.
- `DIV_LAT`, 32: stall cycles for DIV/DIVU/REM/REMU; must be ≥ 1.
- `EN_DIV`, 1: when 0, DIV/REM encodings decode as illegal.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `alu_op` in 2: 00 = ADD, 01 = SUB, 10 = R-type, 11 = I-type.
- `func7` in 7: instruction bits [31:25].
- `func3` in 3: instruction bits [14:12].
- `ex_valid` in 1: EX stage holds a valid instruction.
- `flush` in 1: kill the EX instruction and abort any in-flight multi-cycle op.
- `alu_control` out CTRL_W: ALU/MDU operation code.
- `mc_start` out 1: one-cycle pulse when a multi-cycle op is accepted.
- `mc_done` out 1: one-cycle pulse when the multi-cycle result is valid.
- `stall` out 1: hold IF/ID/EX; bubble into MEM.
- `illegal` out 1: unsupported encoding under `alu_op` 10 or 11.

## Operation
- Codes 0–8 are unchanged from the previous generation: AND 0, OR 1, ADD 2, SLL 3, SRL 4, SUB 6, SLT 7, MUL 8.
- New codes: XOR 5, MULH 9, MULHSU 10, MULHU 11, DIV 12, DIVU 13, REM 14, REMU 15, SRA 16, SLTU 17.
- `alu_op` 00 gives ADD and `alu_op` 01 gives SUB. For both, funct fields are ignored and `illegal` = 0.
- R-type decode:
  - func7 = 0000000 selects the base op by func3.
  - func7 = 0100000 is legal only with func3 000 (SUB) or 101 (SRA).
  - func7 = 0000001 selects an M op by func3.
  - Any other func7 is illegal.
- I-type decode:
  - func7 is ignored except for shifts. func3 001 requires func7 = 0000000. func3 101 uses func7 0000000 for SRL and 0100000 for SRA.
  - ADDI never decodes as SUB.
  - No M ops exist in I-type.
- Illegal encodings: `alu_control` = 0, `illegal` = 1, and no multi-cycle op starts.
- FSM states are IDLE, BUSY. A latched op `op_q` and a down-counter `cnt` of width clog2(max(MUL_LAT, DIV_LAT)) + 1 hold the in-flight operation.
- IDLE:
  - `alu_control` = the current decode.
  - Accept when `ex_valid` && the op is multi-cycle && !`flush`. On accept: `mc_start` = 1, `stall` = 1, `op_q` ← decode, `cnt` ← LAT − 1, next state BUSY.
- BUSY:
  - `alu_control` = `op_q`. Inputs are ignored.
  - While `cnt` ≠ 0: `stall` = 1 and `cnt` decrements.
  - When `cnt` = 0: `mc_done` = 1, `stall` = 0, next state IDLE.
- Single-cycle ops never assert `stall`, `mc_start` or `mc_done`.

## Timing
- Decode (`alu_control`, `illegal`) is combinational from inputs in IDLE, with zero latency.
- For a multi-cycle op accepted in cycle T:
  - `stall` is high in T … T+LAT−1.
  - `mc_done` is high in T+LAT only.
  - The instruction leaves EX at the end of T+LAT.
- In the `mc_done` cycle the same instruction is still in EX, and no new accept is possible. A back-to-back MUL therefore starts at T+LAT+1.
- `flush` has priority over everything:
  - While `flush` = 1, `stall`, `mc_start` and `mc_done` are 0.
  - The next state is IDLE, `cnt` and `op_q` are cleared, and no `mc_done` is ever issued for the aborted op.
- `rst` also has priority:
  - While `rst` = 1, `stall`, `mc_start` and `mc_done` are 0, and `alu_control`/`illegal` follow the combinational decode.
  - After reset: state IDLE, `cnt` = 0, `op_q` = 0.
  - Reset in BUSY aborts exactly like `flush`.
- `rst` and `flush` together behave as reset.
- LAT = 1: `stall` is high in T only and `mc_done` is high in T+1.

## Structure
- Shared package `alu_pkg`:
  - `alu_op` encodings.
  - `alu_control` code constants.
  - func7 constants (BASE, ALT, MULDIV).
  - An `is_multicycle(code)` function.
  - A latency-select helper.
- One sub-module, `alu_decode`: purely combinational, mapping (`alu_op`, `func7`, `func3`, `EN_DIV`) to (`code`, `illegal`, `is_mul`, `is_div`).
- `alu_control_mc` holds the FSM, counter and `op_q` register.

## Test plan
- Sweep all alu_op/func7/func3 combinations -> codes match the tables; e.g. R 0100000/101 → 16; I 0100000/000 → 2 (ADDI); R 1000000/000 → illegal, code 0.
- MUL with ex_valid in cycle 10, MUL_LAT=4 -> mc_start @10; stall high @10–13; mc_done @14; alu_control = 8 throughout.
- DIV with EN_DIV=0 -> illegal = 1, stall never asserted; with EN_DIV=1 and DIV_LAT=32 -> stall for 32 cycles, mc_done after the 32nd.
- Two consecutive MULs -> second mc_start exactly one cycle after the first mc_done; funct inputs changed mid-BUSY leave alu_control unchanged.
- flush at the 2nd BUSY cycle of a DIV -> stall 0 immediately, no mc_done, and a MUL accepted the next cycle starts cleanly.
- rst asserted mid-BUSY, then released -> outputs 0 during reset, state IDLE afterwards; repeat with MUL_LAT=1 -> stall for 1 cycle, mc_done the next cycle.
